// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : E-stage multi-cycle multiply/divide unit owning the HI/LO pair.
//            Results are computed combinationally from latched operands and
//            committed when a load-once down-counter expires.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_cnt_max = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    localparam logic [2:0] c_op_mthi = 3'd4;
    localparam logic [2:0] c_op_mtlo = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;

    logic               r_is_div;
    logic               r_is_signed;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_idle;
    logic               w_accept;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_done;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && start && !op[2];
    assign w_mthi   = w_idle && start && (op == c_op_mthi);
    assign w_mtlo   = w_idle && start && (op == c_op_mtlo);
    assign w_done   = (r_state == ST_RUN) && (r_cnt == c_cnt_one);

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = op[1] ? c_div_load : c_mult_load;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Operands are held for the whole run; starts while busy never reach here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_div    <= 1'b0;
            r_is_signed <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
        end else if (w_accept) begin
            r_is_div    <= op[1];
            r_is_signed <= !op[0];
            r_a         <= RD1;
            r_b         <= RD2;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    logic        w_a_neg;
    logic        w_b_neg;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic        w_div_zero;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_a_neg = r_is_signed && r_a[31];
    assign w_b_neg = r_is_signed && r_b[31];

    // Low 64 bits of the extended product are correct for both signednesses.
    assign w_a_ext = {{32{w_a_neg}}, r_a};
    assign w_b_ext = {{32{w_b_neg}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Sign-magnitude division; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_a_mag    = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_b_mag    = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_div_zero = (r_b == 32'd0);
    assign w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
    assign w_q_mag    = w_a_mag / w_b_safe;
    assign w_r_mag    = w_a_mag % w_b_safe;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            if (w_div_zero) begin
                w_res_hi = r_a;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
            end
        end
    end

    // ------------------------------------------------------------------------
    // HI/LO architectural registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else begin
            if (w_mthi) begin
                r_hi <= RD1;
            end
            if (w_mtlo) begin
                r_lo <= RD1;
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Scoreboard bench for mult_div_unit: driver pushes expected HI/LO
//            and latency, a negedge monitor pops on each observed update.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int MULT_C = 5;
    localparam int DIV_C  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] RD1 = '0;
    logic [31:0] RD2 = '0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mult_div_unit #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .RD1(RD1), .RD2(RD2), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_mt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } txn_t;

    txn_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model straight from the arithmetic definitions.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb2, q, r;
        longint unsigned ua, ub;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (o)
            3'd0: return sa * sb2;
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb2;
                r = sa % sb2;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Call at posedge+1; returns at posedge+1 after the capturing edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        txn_t        t;
        logic [63:0] r;
        if (o == 3'd4 && a == ref_hi) a = ~a;
        if (o == 3'd5 && a == ref_lo) a = ~a;
        start = 1'b1; op = o; RD1 = a; RD2 = b;
        if (o <= 3'd3) begin
            r      = ref_result(o, a, b);
            t.is_mt = 1'b0; t.hi = r[63:32]; t.lo = r[31:0];
            t.lat  = (o <= 3'd1) ? MULT_C : DIV_C;
            ref_hi = t.hi; ref_lo = t.lo;
            sb.push_back(t);
        end else if (o == 3'd4 || o == 3'd5) begin
            if (o == 3'd4) ref_hi = a; else ref_lo = a;
            t.is_mt = 1'b1; t.hi = ref_hi; t.lo = ref_lo; t.lat = 0;
            sb.push_back(t);
        end
        @(posedge clk); #1;
        start = 1'b0; op = 3'd7;
    endtask

    task automatic issue_ignored(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; RD1 = a; RD2 = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd7;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        check("busy_timeout", {63'd0, busy}, 64'd0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: busy falling marks a completion, any other HI/LO change is MTHI/MTLO.
    initial begin
        logic        prev_busy;
        logic [31:0] prev_hi, prev_lo;
        int          bcnt;
        txn_t        t;
        prev_busy = 1'b0; prev_hi = '0; prev_lo = '0; bcnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_busy = 1'b0; prev_hi = HI; prev_lo = LO; bcnt = 0;
                continue;
            end
            if (busy) bcnt++;
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    t = sb.pop_front();
                    check("completion_kind", {63'd0, t.is_mt}, 64'd0);
                    check("result_hi", {32'd0, HI}, {32'd0, t.hi});
                    check("result_lo", {32'd0, LO}, {32'd0, t.lo});
                    check("busy_cycles", 64'(bcnt), 64'(t.lat));
                end
                bcnt = 0;
            end else if (HI !== prev_hi || LO !== prev_lo) begin
                if (sb.size() == 0) begin
                    check("unexpected_update", {HI, LO}, {prev_hi, prev_lo});
                end else begin
                    t = sb.pop_front();
                    check("mt_kind", {63'd0, t.is_mt}, 64'd1);
                    check("mt_hi", {32'd0, HI}, {32'd0, t.hi});
                    check("mt_lo", {32'd0, LO}, {32'd0, t.lo});
                end
            end
            prev_busy = busy; prev_hi = HI; prev_lo = LO;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hi", {32'd0, HI}, 64'd0);
        check("reset_lo", {32'd0, LO}, 64'd0);
        // start while reset is low must be ignored
        start = 1'b1; op = 3'd4; RD1 = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd7;
        reset = 1'b1;
        @(posedge clk); #1;
        check("start_in_reset_hi", {32'd0, HI}, 64'd0);

        issue(3'd0, 32'hFFFF_FFFD, 32'd7); wait_idle();
        check("t1_hi", {32'd0, HI}, {32'd0, 32'hFFFF_FFFF});
        check("t1_lo", {32'd0, LO}, {32'd0, 32'hFFFF_FFEB});
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
        check("t2_hi", {32'd0, HI}, {32'd0, 32'hFFFF_FFFE});
        check("t2_lo", {32'd0, LO}, 64'd1);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2); wait_idle();
        check("t3_div_lo", {32'd0, LO}, {32'd0, 32'hFFFF_FFFD});
        check("t3_div_hi", {32'd0, HI}, {32'd0, 32'hFFFF_FFFF});
        issue(3'd3, 32'd7, 32'd2); wait_idle();
        check("t3_divu", {HI, LO}, {32'd1, 32'd3});
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        check("t4_ovf", {HI, LO}, {32'd0, 32'h8000_0000});
        issue(3'd3, 32'd5, 32'd0); wait_idle();
        check("t4_divu0", {HI, LO}, {32'd5, 32'hFFFF_FFFF});
        issue(3'd2, 32'hFFFF_FFF0, 32'd0); wait_idle();
        check("div0_signed", {HI, LO}, {32'hFFFF_FFF0, 32'hFFFF_FFFF});

        issue(3'd4, 32'h1234_5678, 32'd0);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        issue(3'd5, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_busy", {63'd0, busy}, 64'd0);
        check("mt_pair", {HI, LO}, {32'h1234_5678, 32'h9ABC_DEF0});

        issue(3'd0, 32'd3, 32'd4);
        issue_ignored(3'd0, 32'h0000_FFFF, 32'h0000_FFFF);
        issue_ignored(3'd4, 32'h5555_5555, 32'd0);
        wait_idle();
        check("ignored_start", {HI, LO}, {32'd0, 32'd12});

        issue(3'd6, 32'hAAAA_AAAA, 32'd1);
        issue(3'd7, 32'hBBBB_BBBB, 32'd1);
        check("noop_state", {HI, LO}, {32'd0, 32'd12});

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = rnd_opnd();
            b = rnd_opnd();
            issue(o, a, b);
            if (o <= 3'd3 && $urandom_range(0, 3) == 0)
                issue_ignored(3'($urandom_range(0, 5)), $urandom(), $urandom());
            wait_idle();
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        // Abort a divide two cycles in; nothing may land after release.
        issue(3'd3, 32'd1000, 32'd3);
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        ref_hi = '0; ref_lo = '0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("post_abort_busy", {63'd0, busy}, 64'd0);
        check("post_abort_hilo", {HI, LO}, 64'd0);

        issue(3'd0, 32'h8000_0000, 32'h8000_0000); wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
